pipe_hazard_ctrl: RTL
=====================

# pipe_hazard_ctrl

Hazard and sequencing controller for the five-stage RISC-V pipeline. Drives the stall/flush inputs of the F/D, D/E, E/M and M/W pipeline registers and the PC enable. Generates E-stage forwarding selects and sequences multi-cycle data-memory accesses with a timeout watchdog. Keeps saturating performance counters for stall cycles, branch flushes and load-use bubbles.

## Interface
- TIMEOUT, 255: maximum count of unacknowledged data-memory wait cycles before error (1..2^16-1).
- CNT_W, 32: width of each performance counter.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- rs1_addr_D, rs2_addr_D  in  5  source registers of the instruction in D
- rs1_addr_E, rs2_addr_E  in  5  source registers of the instruction in E
- rd_E  in  5; mem_rd_E  in  1  destination and load flag of E
- rd_M  in  5; reg_wr_M  in  1  destination and write enable of M
- rd_W  in  5; reg_wr_W  in  1  destination and write enable of W
- br_taken_E  in  1  branch/jump in E resolved taken
- mem_req_M  in  1  load/store active in M
- mem_ready  in  1  data memory completes the M access this cycle
- pc_hold  out  1  PC register holds its value
- stall_fd, flush_fd  out  1  F/D register control
- stall_de, flush_de  out  1  D/E register control
- stall_em  out  1  E/M register hold
- flush_mw  out  1  M/W register cleared (bubble)
- fwd_a_E, fwd_b_E  out  2  operand select: 00 register file, 01 from W, 10 from M
- mem_err  out  1  watchdog tripped (level)
- stall_cnt, flush_cnt, lu_cnt  out  CNT_W  performance counters

## Operation
- Combinational hazard terms:
  - mw = mem_req_M & ~mem_ready.
  - lu = mem_rd_E & rd_E≠0 & (rd_E==rs1_addr_D | rd_E==rs2_addr_D).
- Forwarding (fwd_a_E; fwd_b_E identical using rs2_addr_E):
  - 10 if reg_wr_M & rd_M≠0 & rd_M==rs1_addr_E.
  - Else 01 if reg_wr_W & rd_W≠0 & rd_W==rs1_addr_E.
  - Else 00. M has priority over W.
- Priority 1, memory wait (mw=1, or state ERROR):
  - Assert pc_hold, stall_fd, stall_de, stall_em and flush_mw.
  - All other flush outputs 0.
  - br_taken_E is ignored this cycle; E is frozen, so the branch is acted on when the wait ends.
- Priority 2, branch (br_taken_E=1): assert flush_fd and flush_de; pc_hold=0. This overrides lu because the instruction in D is squashed.
- Priority 3, load-use (lu=1): assert pc_hold, stall_fd and flush_de, inserting one bubble into E.
- Otherwise all stall/flush/pc_hold outputs are 0.
- FSM with states RUN, MEM_WAIT, ERROR; 16-bit wait_cnt.
  - RUN: if mw, go to MEM_WAIT and set wait_cnt=1. Otherwise wait_cnt=0.
  - MEM_WAIT, mem_ready=1: go to RUN, wait_cnt=0.
  - MEM_WAIT, mem_ready=0 and wait_cnt==TIMEOUT: go to ERROR.
  - MEM_WAIT, mem_ready=0 otherwise: wait_cnt+1.
  - MEM_WAIT with mem_req_M=0 (illegal): go to RUN.
  - ERROR: mem_err=1; all stages frozen. Only reset exits this state.
- Counters saturate at all-ones and never wrap:
  - stall_cnt +1 each cycle pc_hold=1.
  - flush_cnt +1 each cycle the branch term is active.
  - lu_cnt +1 each cycle the load-use term is active.

## Timing
- While reset=1, the following are forced low: all stall/flush outputs, pc_hold, fwd_*_E, mem_err.
- While reset=1, the FSM is forced to RUN, wait_cnt to 0 and all counters to 0.
- Reset asserted mid-wait or in ERROR returns to RUN immediately, without waiting for a clock edge.
- Stall, flush and forwarding outputs are combinational from current inputs and state, with zero-cycle latency. Pipeline registers sample them at the next rising edge.
- mem_ready is sampled in the same cycle. If mem_ready=1 in the first request cycle, there is no stall and the FSM stays in RUN.
- A memory wait freezes for exactly the number of cycles with mem_ready=0.
- TIMEOUT+1 consecutive unacknowledged cycles: ERROR is entered on the following edge, and mem_err rises in that next cycle.
- Counters update on the rising edge after the qualifying cycle.
- Simultaneous mw and lu: the mw response only. lu is re-evaluated after the wait ends, and lu_cnt is not incremented during the wait.

## Test plan
- lw x5 in E (mem_rd_E=1, rd_E=5), rs1_addr_D=5 -> one cycle of pc_hold=1, stall_fd=1, flush_de=1; lu_cnt=1, stall_cnt=1.
- rd_E=0 with mem_rd_E=1 and rs1_addr_D=0 -> no stall, lu_cnt stays 0.
- rs1_addr_E=7, rd_M=7 with reg_wr_M=1, rd_W=7 with reg_wr_W=1 -> fwd_a_E=10. Then drop reg_wr_M -> fwd_a_E=01. Then rd_W=0 -> fwd_a_E=00.
- br_taken_E=1 together with lu=1 -> flush_fd=1, flush_de=1, pc_hold=0; flush_cnt=1, lu_cnt=0.
- TIMEOUT=4, mem_req_M=1, mem_ready=0, br_taken_E=1:
  - 5 cycles of full freeze with no branch flush, then mem_err=1 persisting.
  - Assert reset -> mem_err=0 and state RUN immediately.
- mem_req_M=1, mem_ready=0 for 3 cycles then 1, with br_taken_E=1 held -> 3 freeze cycles, then flush_fd/flush_de in the ready cycle; stall_cnt=3, mem_err=0.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// Hazard and sequencing controller for the five-stage pipeline: stall/flush
// generation, E-stage forwarding, data-memory wait sequencing and perf counters.
module pipe_hazard_ctrl #(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       rs1_addr_D,
  input  logic [4:0]       rs2_addr_D,
  input  logic [4:0]       rs1_addr_E,
  input  logic [4:0]       rs2_addr_E,
  input  logic [4:0]       rd_E,
  input  logic             mem_rd_E,
  input  logic [4:0]       rd_M,
  input  logic             reg_wr_M,
  input  logic [4:0]       rd_W,
  input  logic             reg_wr_W,
  input  logic             br_taken_E,
  input  logic             mem_req_M,
  input  logic             mem_ready,
  output logic             pc_hold,
  output logic             stall_fd,
  output logic             flush_fd,
  output logic             stall_de,
  output logic             flush_de,
  output logic             stall_em,
  output logic             flush_mw,
  output logic [1:0]       fwd_a_E,
  output logic [1:0]       fwd_b_E,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [CNT_W-1:0] lu_cnt,
  output logic [1:0]       state_dbg
);

  // Debug encoding: RUN=0, MEM_WAIT=1, ERROR=2.
  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERROR    = 2'd2
  } state_t;

  localparam logic [15:0] TIMEOUT_V = 16'(TIMEOUT);

  state_t      state, state_nxt;
  logic [15:0] wait_cnt, wait_cnt_nxt;

  logic mw;
  logic lu;
  logic freeze;
  logic br_act;
  logic lu_act;

  assign mw     = mem_req_M & ~mem_ready;
  assign lu     = mem_rd_E & (rd_E != 5'd0) &
                  ((rd_E == rs1_addr_D) | (rd_E == rs2_addr_D));
  assign freeze = mw | (state == ERROR);
  // A frozen E stage holds its branch, so the branch term only counts when not frozen.
  assign br_act = ~freeze & br_taken_E;
  assign lu_act = ~freeze & ~br_taken_E & lu;

  function automatic logic [1:0] fwd_sel(
    input logic [4:0] rs,
    input logic [4:0] rdm,
    input logic       wrm,
    input logic [4:0] rdw,
    input logic       wrw
  );
    logic [1:0] sel;
    sel = 2'b00;
    if (wrm && (rdm != 5'd0) && (rdm == rs)) sel = 2'b10;
    else if (wrw && (rdw != 5'd0) && (rdw == rs)) sel = 2'b01;
    return sel;
  endfunction

  always_comb begin
    pc_hold  = 1'b0;
    stall_fd = 1'b0;
    flush_fd = 1'b0;
    stall_de = 1'b0;
    flush_de = 1'b0;
    stall_em = 1'b0;
    flush_mw = 1'b0;
    fwd_a_E  = 2'b00;
    fwd_b_E  = 2'b00;
    if (!reset) begin
      if (freeze) begin
        pc_hold  = 1'b1;
        stall_fd = 1'b1;
        stall_de = 1'b1;
        stall_em = 1'b1;
        flush_mw = 1'b1;
      end else if (br_taken_E) begin
        flush_fd = 1'b1;
        flush_de = 1'b1;
      end else if (lu) begin
        pc_hold  = 1'b1;
        stall_fd = 1'b1;
        flush_de = 1'b1;
      end
      fwd_a_E = fwd_sel(rs1_addr_E, rd_M, reg_wr_M, rd_W, reg_wr_W);
      fwd_b_E = fwd_sel(rs2_addr_E, rd_M, reg_wr_M, rd_W, reg_wr_W);
    end
  end

  assign mem_err   = (state == ERROR) & ~reset;
  assign state_dbg = state;

  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    case (state)
      RUN: begin
        if (mw) begin
          state_nxt    = MEM_WAIT;
          wait_cnt_nxt = 16'd1;
        end else begin
          wait_cnt_nxt = 16'd0;
        end
      end
      MEM_WAIT: begin
        if (!mem_req_M || mem_ready) begin
          state_nxt    = RUN;
          wait_cnt_nxt = 16'd0;
        end else if (wait_cnt == TIMEOUT_V) begin
          state_nxt = ERROR;
        end else begin
          wait_cnt_nxt = wait_cnt + 16'd1;
        end
      end
      ERROR: begin
        state_nxt = ERROR;
      end
      default: begin
        state_nxt    = RUN;
        wait_cnt_nxt = 16'd0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= RUN;
      wait_cnt <= 16'd0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
    end
  end

  // Saturating counters: hold at all-ones instead of wrapping.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
      lu_cnt    <= '0;
    end else begin
      if (pc_hold && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_W'(1);
      if (br_act && (flush_cnt != '1)) flush_cnt <= flush_cnt + CNT_W'(1);
      if (lu_act && (lu_cnt != '1)) lu_cnt <= lu_cnt + CNT_W'(1);
    end
  end

endmodule
